// File: rtl/ringbuf_rob.sv
// ringbuf_rob: in-order-retire reorder buffer on a power-of-two circular queue, with per-entry done bits and tag-addressed writeback.
// Optional sticky illegal-request flag o_err when RINGBUF_ROB_ERR_EN is defined.

module ringbuf_rob_entry #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_upd,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic [WIDTH-1:0] i_upd_data,
  output logic             o_alloc,
  output logic             o_done,
  output logic [WIDTH-1:0] o_data
);
  logic             r_alloc;
  logic             r_done;
  logic [WIDTH-1:0] r_data;

  // Push and pop never target the same entry in one cycle; the parent already folds flush into all strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_alloc <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_flush || i_pop) begin
      r_alloc <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_push) begin
      r_alloc <= 1'b1;
      r_done  <= 1'b0;
    end else if (i_upd) begin
      r_done  <= 1'b1;
    end
  end

  // Payload storage is intentionally left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_push)     r_data <= i_push_data;
    else if (i_upd) r_data <= i_upd_data;
  end

  assign o_alloc = r_alloc;
  assign o_done  = r_done;
  assign o_data  = r_data;
endmodule

module ringbuf_rob #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int TAGW  = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [TAGW-1:0]  o_push_tag,
  output logic             o_full,
  input  logic             i_upd,
  input  logic [TAGW-1:0]  i_upd_tag,
  input  logic [WIDTH-1:0] i_upd_data,
  input  logic             i_pop,
  output logic             o_head_valid,
  output logic [WIDTH-1:0] o_head_data,
  output logic [TAGW-1:0]  o_head_tag,
  output logic             o_empty,
  output logic [TAGW:0]    o_count
`ifdef RINGBUF_ROB_ERR_EN
  ,
  output logic             o_err
`endif
);
  localparam logic [TAGW:0] PTR_ONE = (TAGW+1)'(1);

  logic [TAGW:0]                r_head, r_tail;
  logic [TAGW-1:0]              w_head_idx, w_tail_idx;
  logic                         w_empty, w_full, w_head_valid;
  logic                         w_push_ok, w_pop_ok, w_upd_ok;
  logic [DEPTH-1:0]             w_alloc, w_done;
  logic [DEPTH-1:0][WIDTH-1:0]  w_data;

  assign w_head_idx = r_head[TAGW-1:0];
  assign w_tail_idx = r_tail[TAGW-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[TAGW] != r_tail[TAGW]);
  assign w_head_valid = !w_empty && w_done[w_head_idx];

  // All acceptance decisions use pre-edge state; a writeback racing the retiring head is dropped.
  assign w_push_ok = i_push && !w_full && !i_flush;
  assign w_pop_ok  = i_pop && w_head_valid && !i_flush;
  assign w_upd_ok  = i_upd && w_alloc[i_upd_tag] && !i_flush &&
                     !(w_pop_ok && (i_upd_tag == w_head_idx));

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    localparam logic [TAGW-1:0] IDX = TAGW'(g);
    ringbuf_rob_entry #(.WIDTH(WIDTH)) u_ent (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_flush     (i_flush),
      .i_push      (w_push_ok && (w_tail_idx == IDX)),
      .i_upd       (w_upd_ok  && (i_upd_tag  == IDX)),
      .i_pop       (w_pop_ok  && (w_head_idx == IDX)),
      .i_push_data (i_push_data),
      .i_upd_data  (i_upd_data),
      .o_alloc     (w_alloc[g]),
      .o_done      (w_done[g]),
      .o_data      (w_data[g])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_pop_ok)  r_head <= r_head + PTR_ONE;
      if (w_push_ok) r_tail <= r_tail + PTR_ONE;
    end
  end

`ifdef RINGBUF_ROB_ERR_EN
  logic r_err;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_err <= 1'b0;
    else if (i_flush)
      r_err <= 1'b0;
    else if ((i_push && w_full) || (i_pop && !w_head_valid) || (i_upd && !w_alloc[i_upd_tag]))
      r_err <= 1'b1;
  end
  assign o_err = r_err;
`endif

  assign o_push_tag   = w_tail_idx;
  assign o_full       = w_full;
  assign o_empty      = w_empty;
  assign o_count      = r_tail - r_head;
  assign o_head_tag   = w_head_idx;
  assign o_head_valid = w_head_valid;
  assign o_head_data  = w_head_valid ? w_data[w_head_idx] : '0;
endmodule

// File: tb/tb_ringbuf_rob.sv
// Randomized + directed bench for ringbuf_rob (WIDTH=8, DEPTH=4) against an occupancy-count queue model.
module tb_ringbuf_rob;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int TAGW  = 2;

  logic             clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic             push = 1'b0, upd = 1'b0, pop = 1'b0;
  logic [WIDTH-1:0] push_data = '0, upd_data = '0;
  logic [TAGW-1:0]  upd_tag = '0;
  logic [TAGW-1:0]  push_tag, head_tag;
  logic             full, empty, head_valid;
  logic [WIDTH-1:0] head_data;
  logic [TAGW:0]    count;
`ifdef RINGBUF_ROB_ERR_EN
  logic             err;
`endif

  ringbuf_rob #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_push(push), .i_push_data(push_data), .o_push_tag(push_tag), .o_full(full),
    .i_upd(upd), .i_upd_tag(upd_tag), .i_upd_data(upd_data),
    .i_pop(pop), .o_head_valid(head_valid), .o_head_data(head_data), .o_head_tag(head_tag),
    .o_empty(empty), .o_count(count)
`ifdef RINGBUF_ROB_ERR_EN
    , .o_err(err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: head index plus occupancy count, per-slot flags and payloads.
  int         m_head, m_cnt;
  bit         m_alloc [DEPTH];
  bit         m_done  [DEPTH];
  logic [7:0] m_data  [DEPTH];
  bit         m_err;
  int         n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_head = 0; m_cnt = 0; m_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_alloc[i] = 1'b0; m_done[i] = 1'b0; end
  endtask

  task automatic model_apply(input bit p, input logic [7:0] pd, input bit u, input int ut,
                             input logic [7:0] ud, input bit po, input bit fl);
    bit hv, full_m, pop_ok, push_ok, upd_ok;
    int tail;
    if (fl) begin
      model_reset();
      return;
    end
    full_m  = (m_cnt == DEPTH);
    hv      = (m_cnt > 0) && m_done[m_head];
    tail    = (m_head + m_cnt) % DEPTH;
    if ((p && full_m) || (po && !hv) || (u && !m_alloc[ut])) m_err = 1'b1;
    pop_ok  = po && hv;
    push_ok = p && !full_m;
    upd_ok  = u && m_alloc[ut] && !(pop_ok && ut == m_head);
    if (upd_ok) begin m_data[ut] = ud; m_done[ut] = 1'b1; end
    if (pop_ok) begin
      m_alloc[m_head] = 1'b0; m_done[m_head] = 1'b0;
      m_head = (m_head + 1) % DEPTH; m_cnt--;
    end
    if (push_ok) begin
      m_data[tail] = pd; m_done[tail] = 1'b0; m_alloc[tail] = 1'b1; m_cnt++;
    end
  endtask

  task automatic check_outputs();
    bit hv;
    hv = (m_cnt > 0) && m_done[m_head];
    chk("empty",      32'(empty),      32'(m_cnt == 0));
    chk("full",       32'(full),       32'(m_cnt == DEPTH));
    chk("count",      32'(count),      32'(m_cnt));
    chk("push_tag",   32'(push_tag),   32'((m_head + m_cnt) % DEPTH));
    chk("head_tag",   32'(head_tag),   32'(m_head));
    chk("head_valid", 32'(head_valid), 32'(hv));
    chk("head_data",  32'(head_data),  hv ? 32'(m_data[m_head]) : 32'd0);
`ifdef RINGBUF_ROB_ERR_EN
    chk("err",        32'(err),        32'(m_err));
`endif
  endtask

  // Called just after a rising edge: drive, check pre-edge outputs, clock, advance model.
  task automatic step(input bit p, input logic [7:0] pd, input bit u, input int ut,
                      input logic [7:0] ud, input bit po, input bit fl);
    push = p; push_data = pd; upd = u; upd_tag = TAGW'(ut); upd_data = ud; pop = po; flush = fl;
    #3;
    check_outputs();
    @(posedge clk);
    model_apply(p, pd, u, ut, ud, po, fl);
    #1;
    push = 1'b0; upd = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill, then overflow push
    step(1, 8'h11, 0, 0, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0, 0, 0);
    step(1, 8'h44, 0, 0, 0, 0, 0);
    step(1, 8'h55, 0, 0, 0, 0, 0);
    idle();

    // Out-of-order completion and in-order retire
    step(0, 0, 1, 2, 8'hA2, 0, 0);
    step(0, 0, 1, 0, 8'hA0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 8'hA1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle();

    // Wrap rounds keeping several entries live
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 8'h60, 0, 0, 0, 0, 0);
    step(1, 8'h61, 0, 0, 0, 0, 0);
    for (int r = 0; r < 10; r++) begin
      step(1, 8'(8'h70 + r), 1, m_head, 8'(8'h80 + r), 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
    end
    idle();

    // Full with done head: push+pop -> only pop; then push reuses old head tag
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'hC0 + i), 0, 0, 0, 0, 0);
    step(0, 0, 1, m_head, 8'hD0, 0, 0);
    step(1, 8'hE0, 0, 0, 0, 1, 0);
    step(1, 8'hE1, 0, 0, 0, 0, 0);
    // Update + pop on the same done head: update discarded
    step(0, 0, 1, m_head, 8'hD1, 0, 0);
    step(0, 0, 1, m_head, 8'hD2, 1, 0);
    idle();

    // Flush with concurrent push and update, then stale update ignored
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 8'h01, 0, 0, 0, 0, 0);
    step(1, 8'h02, 1, 0, 8'hF0, 0, 0);
    step(1, 8'h03, 1, 2, 8'hF2, 0, 0);
    step(1, 8'h04, 1, 1, 8'hF1, 0, 1);
    step(0, 0, 1, 0, 8'hF3, 0, 0);
    idle();

    // Illegal pop on empty sets sticky error; flush clears it
    step(0, 0, 0, 0, 0, 1, 0);
    idle();
    idle();
    step(0, 0, 0, 0, 0, 0, 1);
    idle();

    // Asynchronous reset between edges with live entries
    step(1, 8'h31, 0, 0, 0, 0, 0);
    step(1, 8'h32, 1, 0, 8'h33, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 6),
           int'($urandom_range(0, DEPTH - 1)), 8'($urandom),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
